// File: rtl/baud_rate_generator.sv
// -----------------------------------------------------------------------------
// baud_rate_generator
//
// Produces a one-clock-wide oversampling strobe (tick) at
// BAUD_RATE * SAMPLE_RATE ticks per second, derived from a CLK_HZ clock.
// The free-running period is DIVISOR+1 clocks, because the clock in which
// tick is high also returns the counter to zero.
//
// Handshake: tick is a pure strobe with no back-pressure. A consumer samples
// it on the rising edge of clock; it is high for exactly one cycle per period
// and never stretched.
//
// Ports:
//   clock    - input clock; all state updates on its rising edge
//   reset    - synchronous, active-high reset; overrides both start inputs
//   start_rx - level-sampled; loads DIVISOR/2 so the next tick is mid-bit
//   start_tx - level-sampled; loads 0 so the next tick is a full period away
//   tick     - combinational strobe, high while counter == DIVISOR
// -----------------------------------------------------------------------------
module baud_rate_generator #(
  parameter int CLK_HZ      = 25_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int SAMPLE_RATE = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic start_rx,
  input  logic start_tx,
  output logic tick
);

  localparam int DIVISOR = CLK_HZ / (BAUD_RATE * SAMPLE_RATE);
  // Two spare bits above what DIVISOR needs; the counter never passes DIVISOR.
  localparam int CW = $clog2(DIVISOR) + 2;

  localparam logic [CW-1:0] DIV_C  = CW'(DIVISOR);
  localparam logic [CW-1:0] HALF_C = CW'(DIVISOR / 2);

  if (DIVISOR < 1) begin : g_bad_config
    $error("baud_rate_generator: DIVISOR must be at least 1 (CLK_HZ too small for BAUD_RATE*SAMPLE_RATE)");
  end

  logic [CW-1:0] counter;

  // Combinational on purpose: the strobe and the counter clear happen in the
  // same cycle, so the consumer sees the tick without a pipeline delay.
  assign tick = (counter == DIV_C);

  // Priority: reset/tick, then start_rx, then start_tx, then count.
  // A start coinciding with a tick is dropped; the tick wins the realignment.
  always_ff @(posedge clock) begin
    if (reset || tick) begin
      counter <= '0;
    end else if (start_rx) begin
      counter <= HALF_C;
    end else if (start_tx) begin
      counter <= '0;
    end else begin
      counter <= counter + CW'(1);
    end
  end

endmodule

// File: tb/tb_baud_rate_generator.sv
// -----------------------------------------------------------------------------
// tb_baud_rate_generator
//
// Drives two instances with identical stimulus: one with default parameters
// (DIVISOR = 162) and one with CLK_HZ=1_600_000, BAUD_RATE=10_000 (DIVISOR=10).
// The reference model tracks the absolute cycle at which the next tick is due
// and derives the expected counter value from that deadline. Every cycle the
// driver pushes {expected counter, expected tick} into a queue per instance;
// a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_baud_rate_generator;

  localparam int DIV_A = 25_000_000 / (9600 * 16);
  localparam int DIV_B = 1_600_000 / (10_000 * 16);
  localparam int CW_A  = $clog2(DIV_A) + 2;
  localparam int CW_B  = $clog2(DIV_B) + 2;

  // clock / reset block
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start_rx = 1'b0;
  logic start_tx = 1'b0;
  logic tick_a;
  logic tick_b;

  always #5 clock = ~clock;

  baud_rate_generator dut_a (
    .clock    (clock),
    .reset    (reset),
    .start_rx (start_rx),
    .start_tx (start_tx),
    .tick     (tick_a)
  );

  baud_rate_generator #(
    .CLK_HZ      (1_600_000),
    .BAUD_RATE   (10_000),
    .SAMPLE_RATE (16)
  ) dut_b (
    .clock    (clock),
    .reset    (reset),
    .start_rx (start_rx),
    .start_tx (start_tx),
    .tick     (tick_b)
  );

  // scoreboard state
  logic [CW_A:0] exp_a_q[$];
  logic [CW_B:0] exp_b_q[$];
  int total = 0;
  int bad   = 0;
  int mon_cyc = 0;

  // reference model state: absolute cycle of next due tick, and whether the
  // current cycle is predicted to carry a tick
  int cyc = 0;
  int nt_a = 0;
  int nt_b = 0;
  bit tk_a = 1'b0;
  bit tk_b = 1'b0;

  // Cycle k is the interval following rising edge k. A clear at edge k puts
  // the tick DIV cycles later; a mid-period load of DIV/2 puts it
  // DIV - DIV/2 cycles later. Expected count = cycles elapsed since the
  // counter was last at zero = DIV minus cycles remaining to the deadline.
  function automatic void model_edge(input int div, input int k, input bit r,
                                     input bit srx, input bit stx,
                                     inout int nt, inout bit tk, output int cnt);
    if (r || tk)     nt = k + div;
    else if (srx)    nt = k + div - div / 2;
    else if (stx)    nt = k + div;
    tk  = (k == nt);
    cnt = div - (nt - k);
  endfunction

  // driver: apply inputs for the next rising edge and record the expectation
  // for the cycle that follows it
  task automatic step(input bit r, input bit srx, input bit stx);
    int cnt;
    reset    = r;
    start_rx = srx;
    start_tx = stx;
    model_edge(DIV_A, cyc, r, srx, stx, nt_a, tk_a, cnt);
    exp_a_q.push_back({CW_A'(cnt), tk_a});
    model_edge(DIV_B, cyc, r, srx, stx, nt_b, tk_b, cnt);
    exp_b_q.push_back({CW_B'(cnt), tk_b});
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // monitor: compare each cycle's DUT outputs against the queued expectation
  always @(negedge clock) begin
    logic [CW_A:0] ea;
    logic [CW_B:0] eb;
    if (exp_a_q.size() > 0) begin
      ea = exp_a_q.pop_front();
      total++;
      if ({dut_a.counter, tick_a} !== ea) begin
        bad++;
        $display("FAIL dut_a cycle %0d: got count=%0d tick=%b, expected count=%0d tick=%b",
                 mon_cyc, dut_a.counter, tick_a, ea[CW_A:1], ea[0]);
      end
    end
    if (exp_b_q.size() > 0) begin
      eb = exp_b_q.pop_front();
      total++;
      if ({dut_b.counter, tick_b} !== eb) begin
        bad++;
        $display("FAIL dut_b cycle %0d: got count=%0d tick=%b, expected count=%0d tick=%b",
                 mon_cyc, dut_b.counter, tick_b, eb[CW_B:1], eb[0]);
      end
      mon_cyc++;
    end
  end

  initial begin
    // reset for one cycle, then free-run through several periods of both
    step(1'b1, 1'b0, 1'b0);
    idle(400);

    // start_rx pulse mid-count
    idle($urandom_range(20, 100));
    step(1'b0, 1'b1, 1'b0);
    idle(200);

    // start_tx pulse mid-count
    idle($urandom_range(20, 100));
    step(1'b0, 1'b0, 1'b1);
    idle(200);

    // start_rx landing on a tick of the default instance
    for (int i = 0; i < 200 && !tk_a; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    idle(200);

    // start_tx landing on a tick of the small instance
    for (int i = 0; i < 20 && !tk_b; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    idle(50);

    // both starts together: start_rx wins
    idle($urandom_range(5, 60));
    step(1'b0, 1'b1, 1'b1);
    idle(100);

    // held starts reapply every cycle
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0);
    idle(30);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b1);
    idle(30);

    // reset mid-count, with starts also asserted
    idle($urandom_range(10, 120));
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    idle(200);

    // randomized traffic
    for (int i = 0; i < 5000; i++) begin
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 79) == 0,
           $urandom_range(0, 79) == 0);
    end
    idle(200);

    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/baud_rate_generator.md
BAUD_RATE_GENERATOR -- requirements
Module: baud_rate_generator

Interface
REQ-001 The module SHALL have parameter CLK_HZ, default 25_000_000, meaning the input clock frequency in Hz.
REQ-002 The module SHALL have parameter BAUD_RATE, default 9600, meaning the serial bit rate in bit/s.
REQ-003 The module SHALL have parameter SAMPLE_RATE, default 16, meaning the oversampling ticks per bit.
REQ-004 The module SHALL have port clock, input, 1 bit: the clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port start_rx, input, 1 bit: receive-start pulse; realigns the counter to mid-period.
REQ-007 The module SHALL have port start_tx, input, 1 bit: transmit-start pulse; realigns the counter to period start.
REQ-008 The module SHALL have port tick, output, 1 bit: oversample strobe, one clock wide.

Function
REQ-009 DIVISOR SHALL equal CLK_HZ / (BAUD_RATE * SAMPLE_RATE), using truncating integer division; the default is 162.
REQ-010 The internal counter SHALL be unsigned, $clog2(DIVISOR)+2 bits wide; the default is 10 bits.
REQ-011 tick SHALL be combinational and high exactly when counter == DIVISOR, with no register stage.
REQ-012 Each rising edge SHALL apply the first matching rule, in this priority order:
- reset or tick: counter <= 0
- start_rx: counter <= DIVISOR/2 (truncating; default 81)
- start_tx: counter <= 0
- otherwise: counter <= counter + 1
REQ-013 In free-run, tick SHALL assert for one cycle every DIVISOR+1 clocks; the default is 163.
REQ-014 After a start_rx edge loads DIVISOR/2, the next tick SHALL occur DIVISOR - DIVISOR/2 clocks later; the default is 81.
REQ-015 After a start_tx edge, the next tick SHALL occur DIVISOR clocks later.
REQ-016 Simultaneous events:
- tick with start_rx or start_tx: counter SHALL go to 0 and the start SHALL be ignored.
- start_rx with start_tx: start_rx SHALL win.
REQ-017 start_rx or start_tx held high for several cycles SHALL reapply its load every cycle, suppressing tick while held.
REQ-018 The counter SHALL never exceed DIVISOR, so no wrap-around occurs.
REQ-019 The start inputs SHALL be level-sampled, with no internal edge detection.
REQ-020 DIVISOR < 1 SHALL be a configuration error flagged at elaboration.

Reset
REQ-021 With reset high at a rising edge, the counter SHALL become 0, overriding start_rx and start_tx.
REQ-022 tick SHALL be 0 while the counter is 0 after reset.
REQ-023 Reset asserted mid-count SHALL abort the current period; counting SHALL restart from 0 after release.

Verification
REQ-024 Reset for 1 cycle with defaults -> counter = 0 and tick = 0.
REQ-025 Defaults, reset released -> the first tick occurs exactly 162 clocks after the release edge, then every 163 clocks, each one cycle wide.
REQ-026 Defaults, start_rx pulsed for one cycle mid-count -> counter = 81 on the next cycle, and tick occurs 81 clocks after the load.
REQ-027 Defaults, start_tx pulsed mid-count -> counter = 0, and tick occurs 162 clocks later.
REQ-028 start_rx asserted in the same cycle as tick -> counter = 0, not 81, and the next tick occurs 162 clocks later.
REQ-029 With CLK_HZ=1_600_000, BAUD_RATE=10_000, SAMPLE_RATE=16 (DIVISOR=10) -> tick every 11 clocks; start_rx gives a tick 5 clocks after the load.
